// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debounce scheduler.
// State encoding is shared by the channel FSM and the top-level busy decode.
package debounce_pkg;

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    localparam int DEFAULT_TICK_M = 500_000;

endpackage

// File: rtl/db_channel_fsm.sv
// One debounce channel: ZERO/WAIT1/ONE/WAIT0 FSM with a tick-boundary wait counter.
// Latency: db follows s after entering a wait plus N_WAIT ticks; no backpressure (en=0 aborts waits).
module db_channel_fsm
    import debounce_pkg::*;
#(
    parameter int N_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic       tick,
    input  logic       en,
    output logic [1:0] state,
    output logic       db
);

    localparam int CNT_W = $clog2(N_WAIT + 1);

    db_state_t        state_reg, state_nxt;
    logic [CNT_W-1:0] cnt_reg, cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ZERO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_nxt;
            cnt_reg   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_reg;
        cnt_nxt   = cnt_reg;
        if (!en) begin
            // Disabled: abandon any wait and fall back to the last accepted level.
            cnt_nxt = '0;
            if (state_reg == WAIT1) state_nxt = ZERO;
            if (state_reg == WAIT0) state_nxt = ONE;
        end else begin
            case (state_reg)
                ZERO: if (s) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = '0;
                end
                WAIT1: if (!s) begin
                    state_nxt = ZERO;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt_reg == CNT_W'(N_WAIT - 1)) begin
                        state_nxt = ONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_reg + 1'b1;
                    end
                end
                ONE: if (!s) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = '0;
                end
                WAIT0: if (s) begin
                    state_nxt = ONE;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt_reg == CNT_W'(N_WAIT - 1)) begin
                        state_nxt = ZERO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ZERO;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign state = state_reg;
    assign db    = (state_reg == ONE) || (state_reg == WAIT0);

endmodule

// File: rtl/mod_m_count.sv
// Free-running modulo-M counter with synchronous clear; max_tick flags count==M-1.
// Latency: max_tick is combinational from the count register; no backpressure (clear only).
module mod_m_count #(
    parameter int M = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic max_tick
);

    localparam int W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count == W'(M - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign max_tick = (count == W'(M - 1));

endmodule

// File: rtl/debounce_scheduler.sv
// N_CH switch debouncer sharing one tick counter; DB_EDGE_PULSE_EN adds db_rise/db_fall pulses.
// Latency: 2 sync + 1 + N_WAIT ticks sw->db; no backpressure, en=0 freezes db and clears the tick.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int TICK_M = DEFAULT_TICK_M,
    parameter int N_WAIT = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] sw,
    input  logic            en,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] db_rise,
    output logic [N_CH-1:0] db_fall,
    output logic            busy,
    output logic            tick
);

    logic [N_CH-1:0] sync1, sync2;
    logic [N_CH-1:0] db_w;
    logic [1:0]      ch_state [N_CH];
    logic            max_tick;
    logic            tick_w;
    logic            busy_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    mod_m_count #(.M(TICK_M)) u_tick_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (~en),
        .max_tick (max_tick)
    );

    assign tick_w = max_tick & en;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_channel_fsm #(.N_WAIT(N_WAIT)) u_fsm (
            .clk     (clk),
            .reset_n (reset_n),
            .s       (sync2[i]),
            .tick    (tick_w),
            .en      (en),
            .state   (ch_state[i]),
            .db      (db_w[i])
        );
    end

    always_comb begin
        busy_w = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_state[i] == WAIT1 || ch_state[i] == WAIT0) busy_w = 1'b1;
        end
    end

`ifdef DB_EDGE_PULSE_EN
    logic [N_CH-1:0] db_q, rise_q, fall_q;

    // db_q lags db by one cycle, so the pulse lands the cycle after db changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            db_q   <= db_w;
            rise_q <= db_w & ~db_q;
            fall_q <= ~db_w & db_q;
        end
    end

    assign db_rise = rise_q;
    assign db_fall = fall_q;
`else
    assign db_rise = '0;
    assign db_fall = '0;
`endif

    assign db   = db_w;
    assign busy = busy_w;
    assign tick = tick_w;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N_CH=4, TICK_M=4, N_WAIT=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_debounce_scheduler;

    localparam int N_CH   = 4;
    localparam int TICK_M = 4;
    localparam int N_WAIT = 3;

`ifdef DB_EDGE_PULSE_EN
    localparam logic PULSE = 1'b1;
`else
    localparam logic PULSE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            en = 1'b0;
    logic [N_CH-1:0] sw = '0;
    logic [N_CH-1:0] db, db_rise, db_fall;
    logic            busy, tick;

    int checks = 0;
    int errors = 0;
    int lat;

    debounce_scheduler #(.N_CH(N_CH), .TICK_M(TICK_M), .N_WAIT(N_WAIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw),
        .en      (en),
        .db      (db),
        .db_rise (db_rise),
        .db_fall (db_fall),
        .busy    (busy),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        en = 1'b1;
        sw = '0;
        reset_n = 1'b0;
        cyc(2);
        chk("rst_db", 32'(db), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_rise", 32'(db_rise), 32'h0);
        chk("rst_fall", 32'(db_fall), 32'h0);

        // Release with sw[0] high: WAIT1 entered on the third edge, counter at 3
        reset_n = 1'b1;
        sw = 4'b0001;
        cyc(2);
        chk("busy_before_wait", 32'(busy), 32'h0);
        cyc(1);
        chk("busy_in_wait1", 32'(busy), 32'h1);
        chk("tick_at_count3", 32'(tick), 32'h1);

        // Asynchronous reset in the middle of the wait
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_db", 32'(db), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        sw = '0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1);
        chk("tick_after_rel_1", 32'(tick), 32'h0);
        cyc(1);
        chk("tick_after_rel_2", 32'(tick), 32'h0);
        cyc(1);
        chk("first_tick", 32'(tick), 32'h1);
        cyc(1);
        chk("tick_wrap", 32'(tick), 32'h0);

        // Clean press on ch0; tick counter is at 0 here, so db rises on edge 12
        sw = 4'b0001;
        lat = 0;
        do begin
            cyc(1);
            lat++;
            if (lat == 5) chk("press_busy", 32'(busy), 32'h1);
        end while (db[0] !== 1'b1 && lat < 30);
        chk("press_lat", 32'(lat), 32'd12);
        chk("press_rise_not_yet", 32'(db_rise), 32'h0);
        cyc(1);
        chk("press_rise_pulse", 32'(db_rise), 32'({3'b000, PULSE}));
        chk("press_busy_done", 32'(busy), 32'h0);
        cyc(1);
        chk("press_rise_gone", 32'(db_rise), 32'h0);

        // Bounce on ch1: 3-cycle levels never survive 3 ticks
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) sw[1] = ~sw[1];
            cyc(1);
            chk("bounce_db1_low", 32'(db[1]), 32'h0);
        end
        sw[1] = 1'b1;
        lat = 0;
        do begin
            cyc(1);
            lat++;
        end while (db[1] !== 1'b1 && lat < 30);
        chk("bounce_lat_in_range", 32'(lat >= 12 && lat <= 15), 32'h1);
        chk("bounce_ch0_kept", 32'(db[0]), 32'h1);

        // Simultaneous release of all channels
        sw = 4'b0000;
        lat = 0;
        do begin
            cyc(1);
            lat++;
        end while (db !== 4'b0000 && lat < 30);
        chk("all_low", 32'(db), 32'h0);
        sw = 4'b1111;
        lat = 0;
        do begin
            cyc(1);
            lat++;
        end while (db === 4'b0000 && lat < 30);
        chk("simul_rise", 32'(db), 32'hf);
        chk("simul_rise_busy", 32'(busy), 32'h0);
        cyc(1);
        chk("simul_rise_pulse", 32'(db_rise), 32'({4{PULSE}}));
        sw = 4'b0000;
        lat = 0;
        do begin
            cyc(1);
            lat++;
        end while (db === 4'b1111 && lat < 30);
        chk("simul_fall", 32'(db), 32'h0);
        chk("simul_fall_rise_quiet", 32'(db_rise), 32'h0);
        cyc(1);
        chk("simul_fall_pulse", 32'(db_fall), 32'({4{PULSE}}));

        // Enable: drop en while ch2 sits in WAIT0
        sw = 4'b0100;
        lat = 0;
        do begin
            cyc(1);
            lat++;
        end while (db[2] !== 1'b1 && lat < 30);
        chk("ch2_high", 32'(db), 32'h4);
        sw = 4'b0000;
        cyc(3);
        chk("ch2_wait0_busy", 32'(busy), 32'h1);
        chk("ch2_wait0_db", 32'(db), 32'h4);
        en = 1'b0;
        #1;
        chk("en0_tick", 32'(tick), 32'h0);
        @(negedge clk);
        cyc(1);
        chk("en0_back_to_one_busy", 32'(busy), 32'h0);
        chk("en0_db_held", 32'(db), 32'h4);
        cyc(10);
        chk("en0_db_still_held", 32'(db), 32'h4);
        chk("en0_busy_idle", 32'(busy), 32'h0);
        chk("en0_tick_idle", 32'(tick), 32'h0);

        // Re-enable with sw[2]=0: counter restarts at 0, db falls on edge 12
        en = 1'b1;
        lat = 0;
        do begin
            cyc(1);
            lat++;
        end while (db[2] !== 1'b0 && lat < 30);
        chk("reen_fall_lat", 32'(lat), 32'd12);
        cyc(1);
        chk("reen_fall_pulse", 32'(db_fall), 32'({1'b0, PULSE, 2'b00}));
        cyc(1);
        chk("reen_fall_gone", 32'(db_fall), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
